// File: rtl/gate_pkg.sv
// Shared opcode definitions and helpers for the reduction gate pipeline.
// Opcodes map onto one of three base reductions, optionally inverted.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    CLS_AND = 2'd0,
    CLS_OR  = 2'd1,
    CLS_XOR = 2'd2
  } base_cls_e;

  function automatic logic is_reserved_op(input logic [2:0] op);
    return (op > OP_XNOR);
  endfunction

  function automatic base_cls_e base_sel(input logic [2:0] op);
    case (op)
      OP_AND, OP_NAND: return CLS_AND;
      OP_OR,  OP_NOR:  return CLS_OR;
      OP_XOR, OP_XNOR: return CLS_XOR;
      default:         return CLS_AND;
    endcase
  endfunction

  function automatic logic is_inverted_op(input logic [2:0] op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

  function automatic logic base_combine(input base_cls_e cls, input logic a, input logic b);
    case (cls)
      CLS_AND: return a & b;
      CLS_OR:  return a | b;
      CLS_XOR: return a ^ b;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reduce_half.sv
// Combinational base reduction of one half of the operand.
module reduce_half
  import gate_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] bits,
  input  base_cls_e    cls,
  output logic         y
);

  always_comb begin
    y = 1'b0;
    case (cls)
      CLS_AND: y = &bits;
      CLS_OR:  y = |bits;
      CLS_XOR: y = ^bits;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/reduce_gate_pipe.sv
// Two-stage valid/ready pipelined N-input reduction gate with a wrapping
// count of consumed results.
module reduce_gate_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic             out_op_err,
  output logic [CNT_W-1:0] result_count
);

  localparam int LO_W = WIDTH / 2;
  localparam int HI_W = WIDTH - LO_W;

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       op_q, op_d;
  logic             p_lo_q, p_lo_d;
  logic             p_hi_q, p_hi_d;
  logic             out_valid_q, out_valid_d;
  logic             out_y_q, out_y_d;
  logic             out_op_err_q, out_op_err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic      s2_adv, s1_adv, consume;
  logic      r_lo, r_hi;
  base_cls_e in_cls, s1_cls;

  assign s2_adv  = ~out_valid_q | out_ready;
  assign s1_adv  = ~s1_valid_q | s2_adv;
  assign consume = out_valid_q & out_ready;
  assign in_cls  = base_sel(in_op);
  assign s1_cls  = base_sel(op_q);

  reduce_half #(.W(LO_W)) u_lo (
    .bits (in_a[LO_W-1:0]),
    .cls  (in_cls),
    .y    (r_lo)
  );

  reduce_half #(.W(HI_W)) u_hi (
    .bits (in_a[WIDTH-1:LO_W]),
    .cls  (in_cls),
    .y    (r_hi)
  );

  always_comb begin
    s1_valid_d   = s1_valid_q;
    op_d         = op_q;
    p_lo_d       = p_lo_q;
    p_hi_d       = p_hi_q;
    out_valid_d  = out_valid_q;
    out_y_d      = out_y_q;
    out_op_err_d = out_op_err_q;
    count_d      = count_q + {{(CNT_W-1){1'b0}}, consume};

    if (s1_adv) begin
      s1_valid_d = in_valid;
      op_d       = in_op;
      p_lo_d     = r_lo;
      p_hi_d     = r_hi;
    end

    // Reserved opcodes force a zero result and flag the error alongside it.
    if (s2_adv) begin
      out_valid_d  = s1_valid_q;
      out_op_err_d = is_reserved_op(op_q);
      out_y_d      = is_reserved_op(op_q) ? 1'b0
                   : (base_combine(s1_cls, p_lo_q, p_hi_q) ^ is_inverted_op(op_q));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      op_q         <= 3'd0;
      p_lo_q       <= 1'b0;
      p_hi_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_y_q      <= 1'b0;
      out_op_err_q <= 1'b0;
      count_q      <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      op_q         <= op_d;
      p_lo_q       <= p_lo_d;
      p_hi_q       <= p_hi_d;
      out_valid_q  <= out_valid_d;
      out_y_q      <= out_y_d;
      out_op_err_q <= out_op_err_d;
      count_q      <= count_d;
    end
  end

  assign in_ready     = s1_adv;
  assign out_valid    = out_valid_q;
  assign out_y        = out_y_q;
  assign out_op_err   = out_op_err_q;
  assign result_count = count_q;

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Directed bench: an 8-bit/8-bit-count instance and a 5-bit/2-bit-count
// instance driven through linear steps with hand-computed expectations.
module tb_reduce_gate_pipe;

  logic       clk = 1'b0;
  logic       reset;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_y, a_out_err;
  logic [2:0] a_in_op;
  logic [7:0] a_in_a;
  logic [7:0] a_count;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_y, b_out_err;
  logic [2:0] b_in_op;
  logic [4:0] b_in_a;
  logic [1:0] b_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reduce_gate_pipe #(.WIDTH(8), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op), .in_a(a_in_a),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_y(a_out_y),
    .out_op_err(a_out_err), .result_count(a_count)
  );

  reduce_gate_pipe #(.WIDTH(5), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_a(b_in_a),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_y(b_out_y),
    .out_op_err(b_out_err), .result_count(b_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [5:0] all_ops_exp;
    int acc;
    int k;

    all_ops_exp = 6'b001110; // bit i = expected out_y for op i over 8'b1011_0110
    reset = 1'b1;
    a_in_valid = 0; a_in_op = 0; a_in_a = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_op = 0; b_in_a = 0; b_out_ready = 1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_count", a_count, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_y", a_out_y, 0);

    // Single AND transaction
    a_in_valid = 1; a_in_op = 3'd0; a_in_a = 8'hFF;
    tick();
    a_in_valid = 0;
    chk("single_s1_only", a_out_valid, 0);
    tick();
    chk("single_valid", a_out_valid, 1);
    chk("single_y", a_out_y, 1);
    chk("single_err", a_out_err, 0);
    tick();
    chk("single_count", a_count, 1);
    chk("single_drained", a_out_valid, 0);

    // All ops back-to-back
    a_in_a = 8'b1011_0110;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        a_in_valid = 1; a_in_op = 3'(i);
        chk($sformatf("ops_in_ready_%0d", i), a_in_ready, 1);
      end else begin
        a_in_valid = 0;
      end
      tick();
      if (i >= 1 && i <= 6) begin
        chk($sformatf("ops_valid_%0d", i - 1), a_out_valid, 1);
        chk($sformatf("ops_y_%0d", i - 1), a_out_y, all_ops_exp[i-1]);
      end
    end
    chk("ops_count", a_count, 7);
    chk("ops_drained", a_out_valid, 0);

    // Backpressure: even txns op1/a=00 -> 0, odd txns op2/a=01 -> 1
    a_out_ready = 0;
    acc = 0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      a_in_valid = 1;
      a_in_op = (k % 2 == 0) ? 3'd1 : 3'd2;
      a_in_a  = (k % 2 == 0) ? 8'h00 : 8'h01;
      if (a_in_ready) begin
        acc++;
        k++;
      end
      tick();
      if (c >= 2) chk($sformatf("bp_stable_y_%0d", c), a_out_y, 0);
    end
    chk("bp_accepted", 32'(acc), 2);
    chk("bp_in_ready", a_in_ready, 0);
    chk("bp_out_valid", a_out_valid, 1);
    chk("bp_count_held", a_count, 7);
    a_in_valid = 0; a_out_ready = 1;
    tick();
    chk("bp_drain1_valid", a_out_valid, 1);
    chk("bp_drain1_y", a_out_y, 1);
    chk("bp_drain1_count", a_count, 8);
    tick();
    chk("bp_drain2_valid", a_out_valid, 0);
    chk("bp_drain2_count", a_count, 9);

    // Reserved opcodes
    a_in_a = 8'hFF;
    a_in_valid = 1; a_in_op = 3'd6;
    tick();
    a_in_op = 3'd7;
    tick();
    a_in_valid = 0;
    chk("rsv6_valid", a_out_valid, 1);
    chk("rsv6_y", a_out_y, 0);
    chk("rsv6_err", a_out_err, 1);
    tick();
    chk("rsv7_y", a_out_y, 0);
    chk("rsv7_err", a_out_err, 1);
    tick();
    chk("rsv_count", a_count, 11);

    // Odd width and counter wrap on the second instance
    b_in_a = 5'b10101; b_in_op = 3'd2;
    for (int i = 0; i < 7; i++) begin
      b_in_valid = (i < 5);
      tick();
      if (i >= 1 && i <= 5) begin
        chk($sformatf("wrap_valid_%0d", i), b_out_valid, 1);
        chk($sformatf("wrap_y_%0d", i), b_out_y, 1);
      end
      if (i >= 2) chk($sformatf("wrap_count_%0d", i), b_count, 32'((i - 1) % 4));
    end

    // Reset with both stages full
    a_out_ready = 0; a_in_valid = 1; a_in_op = 3'd0; a_in_a = 8'hFF;
    tick(); tick();
    a_in_valid = 0;
    chk("mid_full_valid", a_out_valid, 1);
    chk("mid_full_in_ready", a_in_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", a_out_valid, 0);
    chk("mid_rst_count", a_count, 0);
    chk("mid_rst_in_ready", a_in_ready, 1);
    a_out_ready = 1;
    tick();
    chk("mid_no_stale_1", a_out_valid, 0);
    tick();
    chk("mid_no_stale_2", a_out_valid, 0);
    chk("mid_count_idle", a_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
